// File: rtl/alu_operand_issue_pkg.sv
// Shared CPU types for the ALU operand issue stage: selectors, ALU functions
// and the packed ALU input bundle.
package alu_operand_issue_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam logic [XLEN-1:0] ALU_JAL_INCR = 32'd4;

    typedef enum logic [1:0] {
        ALU_RS1_ZERO = 2'd0,
        ALU_RS1_PC   = 2'd1,
        ALU_RS1_RF   = 2'd2
    } alu_rs1_op_t;

    typedef enum logic [1:0] {
        ALU_RS2_LUI_AUIPC = 2'd0,
        ALU_RS2_ARITH_IMM = 2'd1,
        ALU_RS2_JAL_JALR  = 2'd2,
        ALU_RS2_RF        = 2'd3
    } alu_rs2_op_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_fn_t;

    typedef enum logic [1:0] {
        ALU_LOGIC_ADD = 2'd0,
        ALU_LOGIC_XOR = 2'd1,
        ALU_LOGIC_OR  = 2'd2,
        ALU_LOGIC_AND = 2'd3
    } alu_logic_op_t;

    typedef struct packed {
        logic [XLEN:0]        in1;
        logic [XLEN:0]        in2;
        logic                 subtract;
        logic                 arith;
        logic                 lshift;
        logic                 shifter_path;
        logic                 slt_path;
        alu_logic_op_t        logic_op;
        logic [XLEN-1:0]      shifter_in;
        logic [SHAMT_W-1:0]   shift_amount;
    } alu_inputs_t;

endpackage

// File: rtl/alu_operand_issue_if.sv
// Upstream operand request and downstream ALU bundle handshake for the issue stage.
interface alu_operand_issue_if
    import alu_operand_issue_pkg::*;
#(
    parameter int ID_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_rs1_op;
    logic [1:0]        in_rs2_op;
    logic [3:0]        in_fn;
    logic [XLEN-1:0]   in_rf_rs1;
    logic [XLEN-1:0]   in_rf_rs2;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [ID_W-1:0]   in_id;
    logic              out_valid;
    logic              out_ready;
    alu_inputs_t       out_alu;
    logic [ID_W-1:0]   out_id;

    modport master (
        output in_valid, in_rs1_op, in_rs2_op, in_fn, in_rf_rs1, in_rf_rs2,
               in_pc, in_imm, in_id, out_ready,
        input  in_ready, out_valid, out_alu, out_id
    );

    modport slave (
        input  in_valid, in_rs1_op, in_rs2_op, in_fn, in_rf_rs1, in_rf_rs2,
               in_pc, in_imm, in_id, out_ready,
        output in_ready, out_valid, out_alu, out_id
    );
endinterface

// File: rtl/alu_operand_pack.sv
// Combinational mapping of operand selectors, ALU function and data onto the
// packed ALU input bundle.
module alu_operand_pack
    import alu_operand_issue_pkg::*;
(
    input  logic [1:0]      rs1_op,
    input  logic [1:0]      rs2_op,
    input  logic [3:0]      fn,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output alu_inputs_t     alu
);
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            is_slt;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        is_slt = 1'b0;
        alu    = '0;

        case (rs1_op)
            ALU_RS1_PC: op_a = pc;
            ALU_RS1_RF: op_a = rf_rs1;
            default:    op_a = '0;
        endcase

        case (rs2_op)
            ALU_RS2_LUI_AUIPC, ALU_RS2_ARITH_IMM: op_b = imm;
            ALU_RS2_JAL_JALR:                     op_b = ALU_JAL_INCR;
            default:                              op_b = rf_rs2;
        endcase

        // Only signed compare needs sign extension into the extra bit.
        is_slt       = (fn == ALU_SLT);
        alu.in1      = {is_slt & op_a[XLEN-1], op_a};
        alu.in2      = {is_slt & op_b[XLEN-1], op_b};
        alu.logic_op = ALU_LOGIC_ADD;

        case (fn)
            ALU_SUB:  alu.subtract = 1'b1;
            ALU_SLT, ALU_SLTU: begin
                alu.subtract = 1'b1;
                alu.slt_path = 1'b1;
            end
            ALU_XOR:  alu.logic_op = ALU_LOGIC_XOR;
            ALU_OR:   alu.logic_op = ALU_LOGIC_OR;
            ALU_AND:  alu.logic_op = ALU_LOGIC_AND;
            ALU_SLL: begin
                alu.lshift       = 1'b1;
                alu.shifter_path = 1'b1;
            end
            ALU_SRL:  alu.shifter_path = 1'b1;
            ALU_SRA: begin
                alu.arith        = 1'b1;
                alu.shifter_path = 1'b1;
            end
            default: ;
        endcase

        alu.shifter_in   = op_a;
        alu.shift_amount = op_b[SHAMT_W-1:0];
    end
endmodule

// File: rtl/alu_operand_issue.sv
// ALU operand issue stage: packs operands into a registered bundle, with a
// one-entry skid buffer so in_ready never depends combinationally on out_ready.
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    alu_operand_issue_if.slave  bus
);
    generate
        if (XLEN != 32) begin : g_xlen_check
            $error("alu_operand_issue supports XLEN=32 only");
        end
    endgenerate

    alu_inputs_t     pack_alu;
    alu_inputs_t     main_alu_reg;
    alu_inputs_t     skid_alu_reg;
    logic [ID_W-1:0] main_id_reg;
    logic [ID_W-1:0] skid_id_reg;
    logic            main_valid_reg;
    logic            skid_valid_reg;
    logic            in_ready_reg;
    logic            accept;
    logic            drain;
    logic            load_main_new;
    logic            load_skid;
    logic            move_skid;

    alu_operand_pack u_pack (
        .rs1_op (bus.in_rs1_op),
        .rs2_op (bus.in_rs2_op),
        .fn     (bus.in_fn),
        .rf_rs1 (bus.in_rf_rs1),
        .rf_rs2 (bus.in_rf_rs2),
        .pc     (bus.in_pc),
        .imm    (bus.in_imm),
        .alu    (pack_alu)
    );

    // in_ready_reg mirrors !skid_valid, so an accept always sees an empty skid.
    assign accept        = bus.in_valid & in_ready_reg;
    assign drain         = main_valid_reg & bus.out_ready;
    assign load_main_new = accept & (~main_valid_reg | drain);
    assign load_skid     = accept & main_valid_reg & ~drain;
    assign move_skid     = drain & skid_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
            main_alu_reg   <= '0;
            main_id_reg    <= '0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            in_ready_reg   <= 1'b1;
        end else begin
            if (move_skid) begin
                main_alu_reg   <= skid_alu_reg;
                main_id_reg    <= skid_id_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
                in_ready_reg   <= 1'b1;
            end else if (load_main_new) begin
                main_alu_reg   <= pack_alu;
                main_id_reg    <= bus.in_id;
                main_valid_reg <= 1'b1;
            end else if (drain) begin
                main_valid_reg <= 1'b0;
            end
            if (load_skid) begin
                skid_valid_reg <= 1'b1;
                in_ready_reg   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_alu_reg <= pack_alu;
            skid_id_reg  <= bus.in_id;
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = main_valid_reg;
    assign bus.out_alu   = main_alu_reg;
    assign bus.out_id    = main_id_reg;
endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed and randomized-handshake bench for the ALU operand issue stage.
module tb_alu_operand_issue;
    import alu_operand_issue_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   asserts = 0;
    int   fails   = 0;

    alu_operand_issue_if #(.ID_W(4)) bus ();
    alu_inputs_t ref_alu;
    alu_inputs_t o;

    alu_operand_issue #(.ID_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    alu_operand_pack ref_pack (
        .rs1_op (bus.in_rs1_op),
        .rs2_op (bus.in_rs2_op),
        .fn     (bus.in_fn),
        .rf_rs1 (bus.in_rf_rs1),
        .rf_rs2 (bus.in_rf_rs2),
        .pc     (bus.in_pc),
        .imm    (bus.in_imm),
        .alu    (ref_alu)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] r1, input logic [1:0] r2, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] im, input logic [3:0] id);
        bus.in_valid  = 1'b1;
        bus.in_rs1_op = r1;
        bus.in_rs2_op = r2;
        bus.in_fn     = f;
        bus.in_rf_rs1 = a;
        bus.in_rf_rs2 = b;
        bus.in_pc     = p;
        bus.in_imm    = im;
        bus.in_id     = id;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL por_state: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b0;
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'h1, 32'h2, 32'h0, 32'h0, 4'd3);
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'h5, 32'h6, 32'h0, 32'h0, 4'd4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        asserts++; if (bus.out_alu !== '0 || bus.out_id !== 4'd0) begin fails++;
            $display("FAIL reset_data: out_alu=%h out_id=%0d want 0/0", bus.out_alu, bus.out_id); end
        @(negedge clk); idle(); rst_n = 1'b1;
        @(negedge clk);
        asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL post_reset_empty: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                o = bus.out_alu;
                asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'(i-1)) begin fails++;
                    $display("FAIL b2b_id%0d: valid=%b id=%0d want 1/%0d", i-1, bus.out_valid, bus.out_id, i-1); end
                asserts++; if (o.in1 !== {1'b0, 32'(32'h11 * (i-1))} || o.in2 !== 33'h7) begin fails++;
                    $display("FAIL b2b_data%0d: in1=%h in2=%h want %h/7", i-1, o.in1, o.in2, 32'h11*(i-1)); end
            end
            if (i < 3) drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'h11 * i, 32'h7, 32'h0, 32'h0, 4'(i));
            else idle();
            asserts++; if (bus.in_ready !== 1'b1) begin fails++;
                $display("FAIL b2b_ready: in_ready=%b want 1", bus.in_ready); end
        end
        @(negedge clk);
        asserts++; if (bus.out_valid !== 1'b0) begin fails++;
            $display("FAIL b2b_empty: out_valid=%b want 0", bus.out_valid); end
        $display("test_back_to_back done");
    endtask

    task automatic test_slt();
        bus.out_ready = 1'b1;
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd1);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.in1 !== 33'h1_FFFF_FFFF || o.in2 !== 33'h0_0000_0001) begin fails++;
            $display("FAIL slt_pad: in1=%h in2=%h want 1ffffffff/000000001", o.in1, o.in2); end
        asserts++; if (o.subtract !== 1'b1 || o.slt_path !== 1'b1 || o.shifter_path !== 1'b0) begin fails++;
            $display("FAIL slt_flags: sub=%b slt=%b shf=%b want 1/1/0", o.subtract, o.slt_path, o.shifter_path); end
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 4'd2);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.in1 !== 33'h0_FFFF_FFFF || o.subtract !== 1'b1 || o.slt_path !== 1'b1) begin fails++;
            $display("FAIL sltu_pad: in1=%h sub=%b slt=%b want 0ffffffff/1/1", o.in1, o.subtract, o.slt_path); end
        idle();
        @(negedge clk);
        $display("test_slt done");
    endtask

    task automatic test_jal_shift();
        bus.out_ready = 1'b1;
        @(negedge clk); drive(ALU_RS1_PC, ALU_RS2_JAL_JALR, ALU_ADD, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1000, 32'h55, 4'd5);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.in1 !== 33'h1000 || o.in2 !== 33'h4 || o.logic_op !== ALU_LOGIC_ADD || o.subtract !== 1'b0) begin fails++;
            $display("FAIL jal: in1=%h in2=%h lop=%0d sub=%b want 1000/4/0/0", o.in1, o.in2, o.logic_op, o.subtract); end
        drive(ALU_RS1_RF, ALU_RS2_ARITH_IMM, ALU_SRA, 32'h8000_0000, 32'h0, 32'h0, 32'h23, 4'd6);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.shifter_in !== 32'h8000_0000 || o.shift_amount !== 5'd3 || o.in1 !== 33'h0_8000_0000 || o.in2 !== 33'h23) begin fails++;
            $display("FAIL sra_data: sin=%h samt=%0d in1=%h in2=%h want 80000000/3/080000000/23", o.shifter_in, o.shift_amount, o.in1, o.in2); end
        asserts++; if (o.arith !== 1'b1 || o.shifter_path !== 1'b1 || o.lshift !== 1'b0) begin fails++;
            $display("FAIL sra_flags: arith=%b shf=%b lsh=%b want 1/1/0", o.arith, o.shifter_path, o.lshift); end
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_SLL, 32'h3, 32'hFFFF_FFE1, 32'h0, 32'h0, 4'd7);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.lshift !== 1'b1 || o.shifter_path !== 1'b1 || o.arith !== 1'b0 || o.shift_amount !== 5'd1) begin fails++;
            $display("FAIL sll: lsh=%b shf=%b arith=%b samt=%0d want 1/1/0/1", o.lshift, o.shifter_path, o.arith, o.shift_amount); end
        drive(2'b11, ALU_RS2_LUI_AUIPC, ALU_XOR, 32'h1234_5678, 32'h0, 32'h4000, 32'hABCD_E000, 4'd8);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.in1 !== 33'h0 || o.in2 !== 33'h0_ABCD_E000 || o.logic_op !== ALU_LOGIC_XOR) begin fails++;
            $display("FAIL rs1_11_xor: in1=%h in2=%h lop=%0d want 0/0abcde000/1", o.in1, o.in2, o.logic_op); end
        drive(ALU_RS1_RF, ALU_RS2_RF, 4'hF, 32'h8000_0001, 32'h8000_0002, 32'h0, 32'h0, 4'd9);
        @(negedge clk); o = bus.out_alu;
        asserts++; if (o.subtract !== 1'b0 || o.slt_path !== 1'b0 || o.shifter_path !== 1'b0 || o.logic_op !== ALU_LOGIC_ADD || o.in1 !== 33'h0_8000_0001) begin fails++;
            $display("FAIL unused_fn: sub=%b slt=%b shf=%b lop=%0d in1=%h want ADD decode", o.subtract, o.slt_path, o.shifter_path, o.logic_op, o.in1); end
        idle();
        @(negedge clk);
        $display("test_jal_shift done");
    endtask

    task automatic test_stall_skid();
        alu_inputs_t a_alu;
        bus.out_ready = 1'b0;
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hA, 32'h1, 32'h0, 32'h0, 4'd10);
        @(negedge clk); a_alu = bus.out_alu;
        asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd10 || bus.in_ready !== 1'b1 || a_alu.in1 !== 33'hA) begin fails++;
            $display("FAIL stall_a: valid=%b id=%0d rdy=%b in1=%h want 1/10/1/a", bus.out_valid, bus.out_id, bus.in_ready, a_alu.in1); end
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hB, 32'h1, 32'h0, 32'h0, 4'd11);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            asserts++; if (bus.in_ready !== 1'b0 || bus.out_id !== 4'd10 || bus.out_alu !== a_alu) begin fails++;
                $display("FAIL stall_hold%0d: rdy=%b id=%0d alu=%h want 0/10/stable", k, bus.in_ready, bus.out_id, bus.out_alu); end
            drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hC, 32'h1, 32'h0, 32'h0, 4'd12);
        end
        bus.out_ready = 1'b1;
        @(negedge clk); o = bus.out_alu;
        asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd11 || o.in1 !== 33'hB || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL skid_b: valid=%b id=%0d in1=%h rdy=%b want 1/11/b/1", bus.out_valid, bus.out_id, o.in1, bus.in_ready); end
        @(negedge clk); o = bus.out_alu; idle();
        asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd12 || o.in1 !== 33'hC) begin fails++;
            $display("FAIL skid_c: valid=%b id=%0d in1=%h want 1/12/c", bus.out_valid, bus.out_id, o.in1); end
        @(negedge clk);
        asserts++; if (bus.out_valid !== 1'b0) begin fails++;
            $display("FAIL skid_empty: out_valid=%b want 0", bus.out_valid); end
        $display("test_stall_skid done");
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'h8, 32'h0, 32'h0, 32'h0, 4'd1);
        @(negedge clk); drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'h9, 32'h0, 32'h0, 32'h0, 4'd2);
        @(negedge clk);
        asserts++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin fails++;
            $display("FAIL flush_full: rdy=%b valid=%b want 0/1", bus.in_ready, bus.out_valid); end
        flush = 1'b1; drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hA, 32'h0, 32'h0, 32'h0, 4'd3);
        @(negedge clk); flush = 1'b0;
        asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL flush_both: valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hB, 32'h0, 32'h0, 32'h0, 4'd4);
        @(negedge clk);
        asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd4) begin fails++;
            $display("FAIL flush_refill: valid=%b id=%0d want 1/4", bus.out_valid, bus.out_id); end
        flush = 1'b1; bus.out_ready = 1'b1;
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hC, 32'h0, 32'h0, 32'h0, 4'd5);
        @(negedge clk); flush = 1'b0; idle();
        asserts++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++;
            $display("FAIL flush_drop: valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            asserts++; if (bus.out_valid !== 1'b0) begin fails++;
                $display("FAIL flush_ghost%0d: valid=%b id=%0d want 0", k, bus.out_valid, bus.out_id); end
        end
        drive(ALU_RS1_RF, ALU_RS2_RF, ALU_ADD, 32'hD, 32'h0, 32'h0, 32'h0, 4'd6);
        @(negedge clk); idle();
        asserts++; if (bus.out_valid !== 1'b1 || bus.out_id !== 4'd6) begin fails++;
            $display("FAIL flush_after: valid=%b id=%0d want 1/6", bus.out_valid, bus.out_id); end
        @(negedge clk);
        $display("test_flush done");
    endtask

    task automatic test_random();
        alu_inputs_t q_alu[$];
        logic [3:0]  q_id[$];
        logic [3:0]  next_id = 4'd0;
        int          drained = 0;
        for (int c = 0; c < 10020; c++) begin
            @(negedge clk);
            if (c < 10000) begin
                if ($urandom_range(0, 3) != 0)
                    drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          $urandom, $urandom, $urandom, $urandom, next_id);
                else idle();
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                idle();
                bus.out_ready = 1'b1;
            end
            #1;
            asserts++; if (bus.out_valid !== (q_id.size() != 0) || bus.in_ready !== (q_id.size() < 2)) begin fails++;
                $display("FAIL rand_occ c=%0d: valid=%b rdy=%b held=%0d", c, bus.out_valid, bus.in_ready, q_id.size()); end
            if (bus.out_valid === 1'b1 && bus.out_ready && q_id.size() != 0) begin
                asserts++; if (bus.out_id !== q_id[0] || bus.out_alu !== q_alu[0]) begin fails++;
                    $display("FAIL rand_data c=%0d: id=%0d alu=%h want %0d/%h", c, bus.out_id, bus.out_alu, q_id[0], q_alu[0]); end
                void'(q_id.pop_front()); void'(q_alu.pop_front());
                drained++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                q_alu.push_back(ref_alu); q_id.push_back(next_id);
                next_id = next_id + 4'd1;
            end
        end
        asserts++; if (q_id.size() != 0 || bus.out_valid !== 1'b0) begin fails++;
            $display("FAIL rand_leftover: held=%0d valid=%b want 0/0", q_id.size(), bus.out_valid); end
        $display("test_random done: %0d entries drained", drained);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(2'd0, 2'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_back_to_back();
        test_slt();
        test_jal_shift();
        test_stall_skid();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
